// File: rtl/mda_motor_control_ramp.sv
// Speed-command conditioner for the PWM generator: rate-limited duty, dead time on reversal, command watchdog.
// Outputs registered (1 cycle after the deciding edge); cmd_ready is held low for the whole dead-time window.
module mda_motor_control_ramp #(
  parameter logic [15:0] RAMP_DIV = 16'd50000,
  parameter logic [15:0] STEP     = 16'd64,
  parameter logic [15:0] DEADTIME = 16'd5000,
  parameter logic [31:0] TIMEOUT  = 32'd50000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_speed,
  input  logic [15:0] cfg_period,
  output logic        dir,
  output logic        on,
  output logic [15:0] duty_cycle,
  output logic        timeout
);

  typedef enum logic {RUN = 1'b0, DEAD = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [15:0] presc, presc_nxt;
  logic [15:0] dead_cnt, dead_cnt_nxt;
  logic [15:0] target_mag, target_mag_nxt;
  logic        target_dir, target_dir_nxt;
  logic [31:0] wd_cnt, wd_cnt_nxt;
  logic        timeout_nxt, dir_nxt, on_nxt;
  logic [15:0] duty_step, duty_nxt;
  logic        tick, accept;
  logic [16:0] cmd_abs, duty_ext, target_ext, gap;
  logic [15:0] cmd_mag, step_amt;

  assign cmd_ready = (state == RUN);
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (presc == RAMP_DIV - 16'd1);

  // 17-bit magnitude so that -32768 maps to 32768 instead of wrapping
  assign cmd_abs = cmd_speed[15] ? (17'd0 - {1'b1, cmd_speed}) : {1'b0, cmd_speed};
  assign cmd_mag = (cmd_abs > {1'b0, cfg_period}) ? cfg_period : cmd_abs[15:0];

  assign duty_ext   = {1'b0, duty_cycle};
  assign target_ext = {1'b0, target_mag};

  // Distance to the current goal: the target when heading the same way, zero otherwise
  always_comb begin
    gap = 17'd0;
    if (target_dir != dir)          gap = duty_ext;
    else if (duty_ext > target_ext) gap = duty_ext - target_ext;
    else                            gap = target_ext - duty_ext;
  end

  assign step_amt = (gap > {1'b0, STEP}) ? STEP : gap[15:0];

  always_comb begin
    state_nxt      = state;
    presc_nxt      = tick ? 16'd0 : presc + 16'd1;
    dead_cnt_nxt   = dead_cnt;
    target_mag_nxt = target_mag;
    target_dir_nxt = target_dir;
    wd_cnt_nxt     = wd_cnt;
    timeout_nxt    = timeout;
    dir_nxt        = dir;
    duty_step      = duty_cycle;

    case (state)
      RUN: begin
        if (tick) begin
          if ((target_dir == dir) && (duty_cycle < target_mag)) begin
            duty_step = duty_cycle + step_amt;
          end else if ((target_dir != dir) && (duty_cycle == 16'd0) && (target_mag != 16'd0)) begin
            state_nxt    = DEAD;
            dead_cnt_nxt = DEADTIME;
          end else begin
            duty_step = duty_cycle - step_amt;
          end
        end
      end
      DEAD: begin
        duty_step = 16'd0;
        if (dead_cnt == 16'd0) begin
          state_nxt = RUN;
          dir_nxt   = target_dir;
        end else begin
          dead_cnt_nxt = dead_cnt - 16'd1;
        end
      end
      default: state_nxt = RUN;
    endcase

    // An accept landing on the expiry cycle takes priority over the watchdog
    if (accept) begin
      wd_cnt_nxt  = 32'd0;
      timeout_nxt = 1'b0;
      if (cmd_speed != 16'd0) begin
        target_dir_nxt = cmd_speed[15];
        target_mag_nxt = cmd_mag;
      end else begin
        target_mag_nxt = 16'd0;
      end
    end else if ((TIMEOUT != 32'd0) && (wd_cnt != TIMEOUT)) begin
      wd_cnt_nxt = wd_cnt + 32'd1;
      if (wd_cnt + 32'd1 == TIMEOUT) begin
        timeout_nxt    = 1'b1;
        target_mag_nxt = 16'd0;
      end
    end

    if (target_mag_nxt > cfg_period) target_mag_nxt = cfg_period;
    duty_nxt = (duty_step > cfg_period) ? cfg_period : duty_step;
    on_nxt   = (state_nxt == RUN) && (duty_nxt != 16'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      presc      <= 16'd0;
      dead_cnt   <= 16'd0;
      target_mag <= 16'd0;
      target_dir <= 1'b0;
      wd_cnt     <= 32'd0;
      timeout    <= 1'b0;
      dir        <= 1'b0;
      on         <= 1'b0;
      duty_cycle <= 16'd0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      dead_cnt   <= dead_cnt_nxt;
      target_mag <= target_mag_nxt;
      target_dir <= target_dir_nxt;
      wd_cnt     <= wd_cnt_nxt;
      timeout    <= timeout_nxt;
      dir        <= dir_nxt;
      on         <= on_nxt;
      duty_cycle <= duty_nxt;
    end
  end

endmodule
